fpm_round_pack: RTL

Two-stage pipelined normalize/round/pack stage that sits directly downstream of the single-precision mantissa multiplier. It accepts the raw 48-bit significand product, the sign, the bias-adjusted exponent and the operand classes. It produces a correctly rounded (round-to-nearest-even) IEEE-754 binary32 result. Special operands are handled, and a valid/ready handshake provides back-pressure.

---
 rtl/fpm_pkg.sv | 41 ++++
 rtl/fpm_round_pack_if.sv | 38 +++
 rtl/fpm_rne_round.sv | 27 ++
 rtl/fpm_round_pack.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fpm_pkg.sv
// Shared types and constants for the binary32 multiplier round/pack stage.
// Class encodings, pipeline bundle and flag bit positions.
package fpm_pkg;

    localparam int XLEN    = 32;
    localparam int FP_BIAS = 127;
    localparam int EXP_MAX = 255;
    localparam int MAN_W   = 23;
    localparam int EXP_W   = 8;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'b00,
        CLS_NORM = 2'b01,
        CLS_INF  = 2'b10,
        CLS_NAN  = 2'b11
    } fp_cls_t;

    // flags = {invalid, overflow, underflow, inexact}
    localparam int FLG_INX = 0;
    localparam int FLG_UDF = 1;
    localparam int FLG_OVF = 2;
    localparam int FLG_INV = 3;

    // special-operand outcome decided in stage 1
    localparam logic [1:0] SP_NONE = 2'd0;
    localparam logic [1:0] SP_NAN  = 2'd1;
    localparam logic [1:0] SP_INF  = 2'd2;
    localparam logic [1:0] SP_ZERO = 2'd3;

    typedef struct packed {
        logic              sign;
        logic [1:0]        spec;
        logic [MAN_W-1:0]  man;
        logic              g;
        logic              s;
        logic signed [10:0] e;
    } s1_t;

endpackage

// File: rtl/fpm_round_pack_if.sv
// Handshake bundle between the mantissa multiplier, round/pack and consumer.
// The flags signal exists only when FPM_FLAGS_EN is defined.
interface fpm_round_pack_if;
    import fpm_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic            in_sign;
    logic [9:0]      in_exp;
    logic [47:0]     in_prod;
    logic [1:0]      in_a_class;
    logic [1:0]      in_b_class;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
`ifdef FPM_FLAGS_EN
    logic [3:0]      flags;
`endif

    modport master (
        output in_valid, in_sign, in_exp, in_prod,
        output in_a_class, in_b_class, out_ready,
        input  in_ready, out_valid, result
`ifdef FPM_FLAGS_EN
        , input flags
`endif
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_prod,
        input  in_a_class, in_b_class, out_ready,
        output in_ready, out_valid, result
`ifdef FPM_FLAGS_EN
        , output flags
`endif
    );

endinterface

// File: rtl/fpm_rne_round.sv
// Round-to-nearest-even on a 23-bit fraction with guard and sticky.
// A carry out of the significand clears the fraction and bumps e.
module fpm_rne_round
    import fpm_pkg::*;
(
    input  logic [MAN_W-1:0]  man_i,
    input  logic              g_i,
    input  logic              s_i,
    input  logic signed [10:0] e_i,
    output logic [MAN_W-1:0]  man_o,
    output logic signed [10:0] e_o,
    output logic              inexact_o
);

    logic          up;
    logic [MAN_W:0] sum;

    // increment on guard, ties broken toward an even LSB
    always_comb begin
        up        = g_i & (s_i | man_i[0]);
        sum       = {1'b0, man_i} + {{MAN_W{1'b0}}, up};
        man_o     = sum[MAN_W-1:0];
        e_o       = e_i + {{10{1'b0}}, sum[MAN_W]};
        inexact_o = g_i | s_i;
    end

endmodule

// File: rtl/fpm_round_pack.sv
// Two-stage normalize / RNE round / pack for binary32 multiply.
// Define FPM_FLAGS_EN to add the {inv,ovf,udf,inx} flags output.
module fpm_round_pack
    import fpm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    fpm_round_pack_if.slave  bus
);

    logic              s1_valid;
    logic              s2_valid;
    logic              s1_load;
    logic              s2_load;
    s1_t               s1_d;
    s1_t               s1_q;
    logic              inv_d;
    logic [MAN_W-1:0]  r_man;
    logic signed [10:0] r_e;
    logic              r_inx;
    logic              is_ovf;
    logic              is_udf;
    logic [XLEN-1:0]   res_d;
    logic [XLEN-1:0]   res_q;

    assign s2_load      = !s2_valid || bus.out_ready;
    assign s1_load      = !s1_valid || s2_load;
    assign bus.in_ready = s1_load;
    assign bus.out_valid = s2_valid;
    assign bus.result   = res_q;

    // normalize the product and classify special operands
    always_comb begin
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic any_inf, any_zero;
        logic signed [10:0] e_ext;
        a_nan    = bus.in_a_class == CLS_NAN;
        b_nan    = bus.in_b_class == CLS_NAN;
        a_inf    = bus.in_a_class == CLS_INF;
        b_inf    = bus.in_b_class == CLS_INF;
        a_zero   = bus.in_a_class == CLS_ZERO;
        b_zero   = bus.in_b_class == CLS_ZERO;
        any_inf  = a_inf | b_inf;
        any_zero = a_zero | b_zero;
        inv_d    = any_inf & any_zero;
        e_ext    = {bus.in_exp[9], bus.in_exp};
        s1_d.sign = bus.in_sign;
        if (a_nan || b_nan || inv_d)
            s1_d.spec = SP_NAN;
        else if (any_inf)
            s1_d.spec = SP_INF;
        else if (any_zero)
            s1_d.spec = SP_ZERO;
        else
            s1_d.spec = SP_NONE;
        if (bus.in_prod[47]) begin
            s1_d.man = bus.in_prod[46:24];
            s1_d.g   = bus.in_prod[23];
            s1_d.s   = |bus.in_prod[22:0];
            s1_d.e   = e_ext + 11'sd1;
        end else begin
            s1_d.man = bus.in_prod[45:23];
            s1_d.g   = bus.in_prod[22];
            s1_d.s   = |bus.in_prod[21:0];
            s1_d.e   = e_ext;
        end
    end

    fpm_rne_round u_rnd (
        .man_i     (s1_q.man),
        .g_i       (s1_q.g),
        .s_i       (s1_q.s),
        .e_i       (s1_q.e),
        .man_o     (r_man),
        .e_o       (r_e),
        .inexact_o (r_inx)
    );

    assign is_ovf = r_e >= EXP_MAX;
    assign is_udf = r_e <= 0;

    // pack: specials first, then exponent range on the rounded value
    always_comb begin
        res_d = {s1_q.sign, r_e[EXP_W-1:0], r_man};
        if (s1_q.spec == SP_NAN)
            res_d = CANON_NAN;
        else if (s1_q.spec == SP_INF || (s1_q.spec == SP_NONE && is_ovf))
            res_d = {s1_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (s1_q.spec == SP_ZERO || is_udf)
            res_d = {s1_q.sign, {(XLEN-1){1'b0}}};
    end

    // stage 1 register: loads when empty or advancing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_load) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid)
                s1_q <= s1_d;
        end
    end

    // stage 2 register: result held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            res_q    <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid)
                res_q <= res_d;
        end
    end

`ifdef FPM_FLAGS_EN
    logic       inv_q;
    logic [3:0] flg_d;
    logic [3:0] flg_q;

    assign bus.flags = flg_q;

    // exception flags, aligned with the packed result
    always_comb begin
        flg_d = '0;
        if (s1_q.spec == SP_NAN) begin
            flg_d[FLG_INV] = inv_q;
        end else if (s1_q.spec == SP_NONE) begin
            if (is_ovf) begin
                flg_d[FLG_OVF] = 1'b1;
                flg_d[FLG_INX] = 1'b1;
            end else if (is_udf) begin
                flg_d[FLG_UDF] = 1'b1;
                flg_d[FLG_INX] = 1'b1;
            end else begin
                flg_d[FLG_INX] = r_inx;
            end
        end
    end

    // invalid travels with stage 1, flags with stage 2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_q <= 1'b0;
            flg_q <= '0;
        end else begin
            if (s1_load && bus.in_valid)
                inv_q <= inv_d;
            if (s2_load && s1_valid)
                flg_q <= flg_d;
        end
    end
`else
    logic unused_inx;
    logic unused_inv;
    assign unused_inx = r_inx;
    assign unused_inv = inv_d;
`endif

endmodule
